// File: rtl/soc_event_token_tx.sv
// Multi-source event producer: arbitrates NB_SRC valid/ack sources into a
// BUFFER_WIDTH-slot ring published through per-slot toggle write tokens.
module soc_event_token_tx #(
  parameter int NB_SRC       = 4,
  parameter int EVNT_WIDTH   = 8,
  parameter int BUFFER_WIDTH = 8,
  parameter int CNT_WIDTH    = $clog2(BUFFER_WIDTH + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               enable_i,
  input  logic                               prio_fixed_i,
  input  logic [NB_SRC-1:0]                  src_valid_i,
  input  logic [NB_SRC*EVNT_WIDTH-1:0]       src_data_i,
  output logic [NB_SRC-1:0]                  src_ack_o,
  output logic [BUFFER_WIDTH-1:0]            events_wt_o,
  input  logic [BUFFER_WIDTH-1:0]            events_rp_i,
  output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o,
  output logic [CNT_WIDTH-1:0]               count_o,
  output logic                               full_o
);

  localparam int IDX_W = $clog2(BUFFER_WIDTH);
  localparam int SRC_W = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;

  logic [BUFFER_WIDTH-1:0]            wt_q, wt_d;
  logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] da_q, da_d;
  logic [IDX_W-1:0]                   wr_idx_q, wr_idx_d;
  logic [SRC_W-1:0]                   rr_q, rr_d;
  logic [CNT_WIDTH-1:0]               count_q, count_d;

  logic [BUFFER_WIDTH-1:0] occupied;
  logic                    full;
  logic                    found;
  logic                    eligible;
  logic [SRC_W-1:0]        base;
  logic [SRC_W-1:0]        cand;
  logic [SRC_W-1:0]        grant_idx;
  logic [NB_SRC-1:0]       ack;

  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] a, input int off);
    int s;
    s = int'(a) + off;
    if (s >= NB_SRC) s = s - NB_SRC;
    return SRC_W'(s);
  endfunction

  assign occupied = wt_q ^ events_rp_i;
  assign full     = occupied[wr_idx_q];

  // Search downward in offset so the candidate closest to the base wins last.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    base      = prio_fixed_i ? '0 : rr_q;
    for (int off = NB_SRC - 1; off >= 0; off--) begin
      cand = wrap_add(base, off);
      if (src_valid_i[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    eligible = rst_ni & enable_i & ~full & found;
    ack      = '0;
    if (eligible) ack[grant_idx] = 1'b1;
  end

  always_comb begin
    wt_d     = wt_q;
    da_d     = da_q;
    wr_idx_d = wr_idx_q;
    rr_d     = rr_q;
    if (eligible) begin
      wt_d[wr_idx_q] = ~wt_q[wr_idx_q];
      da_d[wr_idx_q*EVNT_WIDTH +: EVNT_WIDTH] = src_data_i[grant_idx*EVNT_WIDTH +: EVNT_WIDTH];
      wr_idx_d = (wr_idx_q == IDX_W'(BUFFER_WIDTH - 1)) ? '0 : wr_idx_q + 1'b1;
      if (!prio_fixed_i) rr_d = wrap_add(grant_idx, 1);
    end
  end

  always_comb begin
    count_d = '0;
    for (int k = 0; k < BUFFER_WIDTH; k++) count_d = count_d + CNT_WIDTH'(occupied[k]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wt_q     <= '0;
      da_q     <= '0;
      wr_idx_q <= '0;
      rr_q     <= '0;
      count_q  <= '0;
    end else begin
      wt_q     <= wt_d;
      da_q     <= da_d;
      wr_idx_q <= wr_idx_d;
      rr_q     <= rr_d;
      count_q  <= count_d;
    end
  end

  assign src_ack_o   = ack;
  assign events_wt_o = wt_q;
  assign events_da_o = da_q;
  assign count_o     = count_q;
  assign full_o      = full;

endmodule

// File: tb/tb_soc_event_token_tx.sv
// Bench for soc_event_token_tx: directed scenarios plus a randomized run, all
// checked against a ring/token reference model kept in the bench.
module tb_soc_event_token_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        pf;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [7:0]  wt;
  logic [7:0]  rp;
  logic [63:0] da;
  logic [3:0]  cnt;
  logic        full;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0]  m_wt;
  logic [63:0] m_da;
  int          m_widx;
  int          m_rr;
  logic [3:0]  m_cnt;
  logic [3:0]  last_ack;

  always #5 clk = ~clk;

  soc_event_token_tx dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .prio_fixed_i(pf),
    .src_valid_i(valid), .src_data_i(data), .src_ack_o(ack),
    .events_wt_o(wt), .events_rp_i(rp), .events_da_o(da),
    .count_o(cnt), .full_o(full)
  );

  task automatic model_grant(output logic [3:0] ea, output logic ef);
    int base;
    int s;
    ea = '0;
    ef = (m_wt[m_widx] != rp[m_widx]);
    if (rst_n && en && !ef) begin
      base = pf ? 0 : m_rr;
      for (int k = 0; k < 4; k++) begin
        s = (base + k) % 4;
        if (valid[s] && ea == 4'b0) ea[s] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] ea;
    logic       ef;
    logic [7:0] occ;
    int         pc;
    int         g;
    logic [31:0] dsnap;
    model_grant(ea, ef);
    occ = m_wt ^ rp;
    pc = 0;
    for (int k = 0; k < 8; k++) pc += int'(occ[k]);
    g = -1;
    for (int s = 0; s < 4; s++) if (ea[s]) g = s;
    dsnap = data;
    @(posedge clk);
    if (!rst_n) begin
      m_wt = '0; m_da = '0; m_widx = 0; m_rr = 0; m_cnt = '0;
    end else begin
      m_cnt = 4'(pc);
      if (g >= 0) begin
        m_da[m_widx*8 +: 8] = dsnap[g*8 +: 8];
        m_wt[m_widx] = ~m_wt[m_widx];
        m_widx = (m_widx + 1) % 8;
        if (!pf) m_rr = (g + 1) % 4;
      end
    end
    last_ack = ea;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; data = '0; en = 1'b1; pf = 1'b0; rp = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; pf = 1'b0; valid = 4'hF; data = 32'h12345678; rp = '0;
    #1;
    n_cmp++; if (ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0000", ack); end
    tick(); tick();
    n_cmp++; if (wt !== 8'h00) begin n_fail++; $display("FAIL reset_wt got %h exp 00", wt); end
    n_cmp++; if (da !== 64'h0) begin n_fail++; $display("FAIL reset_da got %h exp 0", da); end
    n_cmp++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_cmp++; if (ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack_held got %b exp 0000", ack); end
    valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    valid = 4'b0001; data = 32'h0000_00A5;
    #1;
    n_cmp++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got %b exp 0001", ack); end
    tick();
    valid = '0;
    #1;
    n_cmp++; if (wt !== 8'h01) begin n_fail++; $display("FAIL single_wt got %h exp 01", wt); end
    n_cmp++; if (da[7:0] !== 8'hA5) begin n_fail++; $display("FAIL single_da got %h exp a5", da[7:0]); end
    n_cmp++; if (cnt !== 4'd0) begin n_fail++; $display("FAIL single_cnt_early got %0d exp 0", cnt); end
    tick();
    n_cmp++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL single_cnt got %0d exp 1", cnt); end
  endtask

  task automatic test_rr_stream();
    logic [3:0] ea;
    logic       ef;
    do_reset();
    valid = 4'hF;
    data = $urandom();
    for (int c = 0; c < 12; c++) begin
      #1;
      model_grant(ea, ef);
      n_cmp++; if (ack !== ea || ack !== (4'b1 << (c % 4))) begin
        n_fail++; $display("FAIL rr_ack c=%0d got %b exp %b", c, ack, ea); end
      tick();
      rp = m_wt;
      for (int s = 0; s < 4; s++) if (last_ack[s]) data[s*8 +: 8] = 8'($urandom());
      n_cmp++; if (wt !== m_wt || da !== m_da) begin
        n_fail++; $display("FAIL rr_ring c=%0d got %h/%h exp %h/%h", c, wt, da, m_wt, m_da); end
      if (c == 8) begin
        n_cmp++; if (wt !== 8'hFE) begin n_fail++; $display("FAIL rr_wrap got %h exp fe", wt); end
      end
    end
    valid = '0;
  endtask

  task automatic test_full();
    logic [7:0] d9;
    do_reset();
    valid = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      data[7:0] = 8'($urandom());
      #1;
      n_cmp++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL full_fill_ack c=%0d got %b exp 0001", c, ack); end
      tick();
    end
    d9 = 8'($urandom());
    data[7:0] = d9;
    #1;
    n_cmp++; if (full !== 1'b1 || ack !== 4'b0) begin
      n_fail++; $display("FAIL full_stall got full=%b ack=%b exp 1/0000", full, ack); end
    tick();
    n_cmp++; if (cnt !== 4'd8 || cnt !== m_cnt) begin n_fail++; $display("FAIL full_cnt got %0d exp 8", cnt); end
    n_cmp++; if (wt !== 8'hFF) begin n_fail++; $display("FAIL full_wt got %h exp ff", wt); end
    rp[0] = 1'b1;
    #1;
    n_cmp++; if (ack !== 4'b0001 || full !== 1'b0) begin
      n_fail++; $display("FAIL full_free_ack got ack=%b full=%b exp 0001/0", ack, full); end
    tick();
    valid = '0;
    n_cmp++; if (da[7:0] !== d9 || wt[0] !== 1'b0 || da !== m_da) begin
      n_fail++; $display("FAIL full_slot0 got %h wt=%h exp %h", da[7:0], wt, d9); end
  endtask

  task automatic test_prio();
    logic [3:0] ea;
    logic       ef;
    logic [3:0] prev;
    do_reset();
    pf = 1'b1; valid = 4'b1010; data = $urandom();
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL prio_fixed c=%0d got %b exp 0010", c, ack); end
      tick();
      rp = m_wt;
    end
    pf = 1'b0;
    prev = 4'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      model_grant(ea, ef);
      n_cmp++; if (ack !== ea || ack === prev || !(ack == 4'b0010 || ack == 4'b1000)) begin
        n_fail++; $display("FAIL prio_rr c=%0d got %b exp %b", c, ack, ea); end
      prev = ack;
      tick();
      rp = m_wt;
    end
    valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin data[7:0] = 8'($urandom()); tick(); end
    valid = 4'hF;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ack !== 4'b0) begin n_fail++; $display("FAIL rmid_ack got %b exp 0000", ack); end
    tick();
    n_cmp++; if (wt !== 8'h0 || da !== 64'h0 || cnt !== 4'd0 || ack !== 4'b0) begin
      n_fail++; $display("FAIL rmid_outs got wt=%h da=%h cnt=%0d ack=%b exp zeros", wt, da, cnt, ack); end
    rst_n = 1'b1; rp = '0; valid = 4'b0001; data[7:0] = 8'h3C;
    tick();
    valid = '0;
    n_cmp++; if (wt !== 8'h01 || da[7:0] !== 8'h3C) begin
      n_fail++; $display("FAIL rmid_first got wt=%h d0=%h exp 01/3c", wt, da[7:0]); end
    tick();
    n_cmp++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL rmid_cnt got %0d exp 1", cnt); end
  endtask

  task automatic test_enable();
    logic [7:0] wt_hold;
    do_reset();
    valid = 4'hF; data = $urandom();
    tick(); rp = m_wt;
    tick(); rp = m_wt;
    en = 1'b0;
    wt_hold = m_wt;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (ack !== 4'b0) begin n_fail++; $display("FAIL en_low_ack c=%0d got %b exp 0000", c, ack); end
      tick();
      n_cmp++; if (wt !== wt_hold) begin n_fail++; $display("FAIL en_low_wt got %h exp %h", wt, wt_hold); end
    end
    en = 1'b1;
    #1;
    n_cmp++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL en_rise_ack got %b exp 0100", ack); end
    tick();
    valid = '0;
  endtask

  task automatic test_random();
    logic [3:0] ea;
    logic       ef;
    logic [3:0] pend;
    do_reset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) pf = ~pf;
      for (int s = 0; s < 4; s++)
        if (!pend[s] && $urandom_range(0, 1) == 1) begin
          pend[s] = 1'b1; data[s*8 +: 8] = 8'($urandom());
        end
      valid = pend;
      #1;
      model_grant(ea, ef);
      n_cmp++; if (ack !== ea || full !== ef) begin
        n_fail++; $display("FAIL rand_ack c=%0d got %b/%b exp %b/%b", c, ack, full, ea, ef); end
      tick();
      n_cmp++; if (wt !== m_wt || da !== m_da || cnt !== m_cnt) begin
        n_fail++; $display("FAIL rand_state c=%0d got %h/%h/%0d exp %h/%h/%0d", c, wt, da, cnt, m_wt, m_da, m_cnt); end
      for (int s = 0; s < 4; s++) if (last_ack[s]) pend[s] = 1'b0;
      for (int k = 0; k < 8; k++)
        if (m_wt[k] != rp[k] && $urandom_range(0, 3) == 0) rp[k] = ~rp[k];
    end
    valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pf = 1'b0; valid = '0; data = '0; rp = '0;
    m_wt = '0; m_da = '0; m_widx = 0; m_rr = 0; m_cnt = '0; last_ack = '0;
    #1;
    test_reset();
    test_single();
    test_rr_stream();
    test_full();
    test_prio();
    test_reset_mid();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
